// File: rtl/sm_mem_arbiter.sv
// rtl/sm_mem_arbiter.sv - two-port arbiter sharing one single-port synchronous memory
module sm_mem_arbiter #(
  parameter int LATENCY = 1,
  parameter bit RR      = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic [31:0] memAddr,
  output logic        memWe,
  output logic [31:0] memWdata,
  input  logic [31:0] memRdata,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t     state;
  state_t     nextState;
  logic [3:0] cnt;
  logic       lastOwner;
  logic       isWrite;
  logic       grant;
  logic       winner;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      lastOwner <= 1'b1;
      owner     <= 1'b0;
      isWrite   <= 1'b0;
      memAddr   <= 32'd0;
      memWe     <= 1'b0;
      memWdata  <= 32'd0;
      rdata0    <= 32'd0;
      rdata1    <= 32'd0;
    end else begin
      state <= nextState;
      memWe <= 1'b0;
      if (grant) begin
        // Port inputs are sampled only here; later changes wait for the next grant.
        owner     <= winner;
        lastOwner <= winner;
        cnt       <= 4'(LATENCY);
        isWrite   <= winner ? we1 : we0;
        memWe     <= winner ? we1 : we0;
        memAddr   <= winner ? addr1 : addr0;
        memWdata  <= winner ? wdata1 : wdata0;
      end else if (state == ACCESS) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1 && !isWrite) begin
          if (owner) rdata1 <= memRdata;
          else       rdata0 <= memRdata;
        end
      end
    end
  end

  always_comb begin
    grant     = 1'b0;
    winner    = 1'b0;
    nextState = state;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          grant     = 1'b1;
          winner    = (req0 && req1) ? (RR ? ~lastOwner : 1'b0) : req1;
          nextState = ACCESS;
        end
      end
      ACCESS:  if (cnt == 4'd1) nextState = RESP;
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Decoded from registered state only, so no input reaches an output combinationally.
  always_comb begin
    busy = (state != IDLE);
    ack0 = (state == RESP) && !owner;
    ack1 = (state == RESP) && owner;
  end

endmodule

// File: tb/tb_sm_mem_arbiter.sv
// tb/tb_sm_mem_arbiter.sv - directed self-checking bench for sm_mem_arbiter
module tb_sm_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;

  logic        a0 [4];
  logic        a1 [4];
  logic        mWe [4];
  logic        bsy [4];
  logic        own [4];
  logic [31:0] rd0 [4];
  logic [31:0] rd1 [4];
  logic [31:0] mAddr [4];
  logic [31:0] mWdata [4];
  logic [31:0] mRdata [4];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] memModel(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : (a ^ 32'hA5A5_0000);
  endfunction

  assign mRdata[0] = memModel(mAddr[0]);
  assign mRdata[1] = memModel(mAddr[1]);
  assign mRdata[2] = memModel(mAddr[2]);
  assign mRdata[3] = memModel(mAddr[3]);

  // 0: L1 round-robin, 1: L1 fixed priority, 2: L3 round-robin, 3: L4 round-robin
  sm_mem_arbiter #(.LATENCY(1), .RR(1'b1)) uRr1 (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .we0(we0), .we1(we1), .wdata0(wdata0), .wdata1(wdata1), .ack0(a0[0]), .ack1(a1[0]),
    .rdata0(rd0[0]), .rdata1(rd1[0]), .memAddr(mAddr[0]), .memWe(mWe[0]),
    .memWdata(mWdata[0]), .memRdata(mRdata[0]), .busy(bsy[0]), .owner(own[0]));

  sm_mem_arbiter #(.LATENCY(1), .RR(1'b0)) uFix1 (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .we0(we0), .we1(we1), .wdata0(wdata0), .wdata1(wdata1), .ack0(a0[1]), .ack1(a1[1]),
    .rdata0(rd0[1]), .rdata1(rd1[1]), .memAddr(mAddr[1]), .memWe(mWe[1]),
    .memWdata(mWdata[1]), .memRdata(mRdata[1]), .busy(bsy[1]), .owner(own[1]));

  sm_mem_arbiter #(.LATENCY(3), .RR(1'b1)) uRr3 (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .we0(we0), .we1(we1), .wdata0(wdata0), .wdata1(wdata1), .ack0(a0[2]), .ack1(a1[2]),
    .rdata0(rd0[2]), .rdata1(rd1[2]), .memAddr(mAddr[2]), .memWe(mWe[2]),
    .memWdata(mWdata[2]), .memRdata(mRdata[2]), .busy(bsy[2]), .owner(own[2]));

  sm_mem_arbiter #(.LATENCY(4), .RR(1'b1)) uRr4 (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .we0(we0), .we1(we1), .wdata0(wdata0), .wdata1(wdata1), .ack0(a0[3]), .ack1(a1[3]),
    .rdata0(rd0[3]), .rdata1(rd1[3]), .memAddr(mAddr[3]), .memWe(mWe[3]),
    .memWdata(mWdata[3]), .memRdata(mRdata[3]), .busy(bsy[3]), .owner(own[3]));

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Returns on the negedge where rst_n is released (that cycle is IDLE).
  task automatic doReset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset values on every instance
    rst_n = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      checkVal($sformatf("rst_flags%0d", k), {27'd0, a0[k], a1[k], mWe[k], bsy[k], own[k]}, 32'd0);
      checkVal($sformatf("rst_addr%0d", k), mAddr[k], 32'd0);
      checkVal($sformatf("rst_wdata%0d", k), mWdata[k], 32'd0);
      checkVal($sformatf("rst_rd0_%0d", k), rd0[k], 32'd0);
      checkVal($sformatf("rst_rd1_%0d", k), rd1[k], 32'd0);
    end

    // Single read, LATENCY=1
    doReset();
    req0 = 1'b1; addr0 = 32'h10;
    tick();
    checkVal("rd_addr_c1", mAddr[0], 32'h10);
    checkVal("rd_busy_c1", {31'd0, bsy[0]}, 32'd1);
    checkVal("rd_ack0_c1", {31'd0, a0[0]}, 32'd0);
    tick();
    checkVal("rd_ack0_c2", {31'd0, a0[0]}, 32'd1);
    checkVal("rd_ack1_c2", {31'd0, a1[0]}, 32'd0);
    checkVal("rd_data_c2", rd0[0], 32'hDEADBEEF);
    req0 = 1'b0;
    tick();
    checkVal("rd_busy_c3", {31'd0, bsy[0]}, 32'd0);
    checkVal("rd_ack0_c3", {31'd0, a0[0]}, 32'd0);

    // Round-robin (inst 0) and fixed priority (inst 1) under the same contention
    req0 = 1'b1; req1 = 1'b1; addr0 = 32'h4; addr1 = 32'h8;
    doReset();
    for (int k = 0; k < 4; k++) begin
      tick();
      checkVal($sformatf("rr_addr%0d", k), mAddr[0], (k % 2 == 0) ? 32'h4 : 32'h8);
      checkVal($sformatf("fp_addr%0d", k), mAddr[1], 32'h4);
      tick();
      checkVal($sformatf("rr_ack0_%0d", k), {31'd0, a0[0]}, (k % 2 == 0) ? 32'd1 : 32'd0);
      checkVal($sformatf("rr_ack1_%0d", k), {31'd0, a1[0]}, (k % 2 == 0) ? 32'd0 : 32'd1);
      checkVal($sformatf("fp_ack0_%0d", k), {31'd0, a0[1]}, 32'd1);
      checkVal($sformatf("fp_ack1_%0d", k), {31'd0, a1[1]}, 32'd0);
      if (k == 3) req0 = 1'b0;
      tick();
      checkVal($sformatf("rr_idle%0d", k), {31'd0, bsy[0]}, 32'd0);
      checkVal($sformatf("fp_idle%0d", k), {31'd0, bsy[1]}, 32'd0);
    end
    tick();
    checkVal("fp_p1_addr", mAddr[1], 32'h8);
    checkVal("fp_p1_owner", {31'd0, own[1]}, 32'd1);
    tick();
    checkVal("fp_p1_ack", {31'd0, a1[1]}, 32'd1);
    req1 = 1'b0;

    // Write on port 1, LATENCY=3, preceded by a read to give rdata1 a known value
    addr0 = 32'h0; addr1 = 32'h40; we1 = 1'b0;
    doReset();
    req1 = 1'b1;
    tick(); tick(); tick(); tick();
    checkVal("w_pre_ack", {31'd0, a1[2]}, 32'd1);
    checkVal("w_pre_rd1", rd1[2], 32'hA5A50040);
    req1 = 1'b0;
    tick();
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h20; wdata1 = 32'h12345678;
    tick();
    checkVal("w_we_c1", {31'd0, mWe[2]}, 32'd1);
    checkVal("w_addr_c1", mAddr[2], 32'h20);
    checkVal("w_wdata_c1", mWdata[2], 32'h12345678);
    tick();
    checkVal("w_we_c2", {31'd0, mWe[2]}, 32'd0);
    checkVal("w_addr_c2", mAddr[2], 32'h20);
    tick();
    checkVal("w_we_c3", {31'd0, mWe[2]}, 32'd0);
    tick();
    checkVal("w_ack1_c4", {31'd0, a1[2]}, 32'd1);
    checkVal("w_rd1_c4", rd1[2], 32'hA5A50040);
    req1 = 1'b0; we1 = 1'b0;
    tick();
    checkVal("w_idle_c5", {31'd0, bsy[2]}, 32'd0);

    // Reset mid-access, LATENCY=4
    addr0 = 32'h50;
    doReset();
    req0 = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checkVal("ra_busy", {31'd0, bsy[3]}, 32'd0);
    checkVal("ra_ack0", {31'd0, a0[3]}, 32'd0);
    checkVal("ra_addr", mAddr[3], 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    checkVal("ra_regrant_addr", mAddr[3], 32'h50);
    checkVal("ra_regrant_busy", {31'd0, bsy[3]}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkVal($sformatf("ra_noack%0d", k), {31'd0, a0[3]}, 32'd0);
    end
    tick();
    checkVal("ra_ack0", {31'd0, a0[3]}, 32'd1);
    checkVal("ra_rd0", rd0[3], 32'hA5A50050);

    // Address change after grant is ignored until the next grant
    addr0 = 32'h10;
    tick();
    checkVal("ic_idle", {31'd0, bsy[3]}, 32'd0);
    tick();
    checkVal("ic_addr_c1", mAddr[3], 32'h10);
    addr0 = 32'h30;
    for (int k = 2; k <= 4; k++) begin
      tick();
      checkVal($sformatf("ic_addr_c%0d", k), mAddr[3], 32'h10);
    end
    tick();
    checkVal("ic_ack0", {31'd0, a0[3]}, 32'd1);
    checkVal("ic_rd0", rd0[3], 32'hDEADBEEF);
    tick();
    tick();
    checkVal("ic_next_addr", mAddr[3], 32'h30);
    req0 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
